// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI receiver: FSM encoding, dc tag values and
// the packing order of the oversampled SPI pins.
package oled_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } spi_state_e;

  localparam logic OLED_DC_CMD  = 1'b0;
  localparam logic OLED_DC_DATA = 1'b1;

  // Bit positions of the SPI pins inside the packed synchroniser word.
  localparam int unsigned PIN_SCK  = 0;
  localparam int unsigned PIN_MOSI = 1;
  localparam int unsigned PIN_CS   = 2;
  localparam int unsigned PIN_DC   = 3;
  localparam int unsigned PIN_RST  = 4;
  localparam int unsigned PIN_NUM  = 5;

  // Idle line levels: sck low, cs high, panel reset released.
  localparam logic [PIN_NUM-1:0] PIN_IDLE = 5'b10100;

endpackage

// File: rtl/oled_rx_fifo.sv
// Synchronous FIFO holding received {dc,data} entries, with a synchronous flush.
// Read data is zero whenever the FIFO is empty.
module oled_rx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/oled_spi_rx.sv
// Oversampling SPI mode-0 receiver for the OLED link; delivers dc-tagged bytes on
// a valid/ready stream. Define OLED_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO.
module oled_spi_rx
  import oled_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        oled_sck,
  input  logic        oled_mosi,
  input  logic        oled_cs,
  input  logic        oled_dc,
  input  logic        oled_rst,
  output logic [7:0]  rx_data,
  output logic        rx_dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_overrun,
  output logic        rx_frame_err,
  output logic [15:0] rx_byte_cnt
);

  logic [PIN_NUM-1:0] pins;
  logic [PIN_NUM-1:0] sync_q [SYNC_STAGES];
  logic [PIN_NUM-1:0] pin_s;
  logic               sck_d;
  logic               sck_rise;
  logic               live;

  spi_state_e state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] byte_nxt;
  logic       byte_done;
  logic       frame_err_nxt;
  logic       accept;
  logic       can_store;

  assign pins = {oled_rst, oled_dc, oled_cs, oled_mosi, oled_sck};

  // NOTE: sequential state always uses non-blocking assignment so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_IDLE;
      sck_d <= 1'b0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sck_d <= sync_q[SYNC_STAGES-1][PIN_SCK];
    end
  end

  assign pin_s    = sync_q[SYNC_STAGES-1];
  assign live     = pin_s[PIN_RST];
  assign sck_rise = pin_s[PIN_SCK] & ~sck_d;
  assign byte_nxt = {shift[6:0], pin_s[PIN_MOSI]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    byte_done     = 1'b0;
    frame_err_nxt = 1'b0;
    if (!live) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      shift_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          bit_cnt_nxt = '0;
          if (!pin_s[PIN_CS]) state_nxt = ST_RECV;
        end
        ST_RECV: begin
          if (sck_rise) begin
            shift_nxt = byte_nxt;
            if (bit_cnt == 3'd7) begin
              byte_done   = 1'b1;
              bit_cnt_nxt = '0;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
          if (pin_s[PIN_CS]) begin
            state_nxt     = ST_IDLE;
            bit_cnt_nxt   = '0;
            frame_err_nxt = (bit_cnt != 3'd0) && !byte_done;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_byte_cnt  <= '0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift        <= shift_nxt;
      rx_frame_err <= frame_err_nxt;
      rx_overrun   <= byte_done && !can_store;
      if (byte_done) rx_byte_cnt <= rx_byte_cnt + 16'd1;
    end
  end

  assign accept = rx_valid && rx_ready;

`ifdef OLED_RX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  assign can_store = !fifo_full || accept;
  assign rx_valid  = !fifo_empty;

  oled_rx_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .flush   (!live),
    .push    (byte_done),
    .wr_data ({pin_s[PIN_DC], byte_nxt}),
    .pop     (accept),
    .rd_data ({rx_dc, rx_data}),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );
`else
  // A byte completing in the same cycle as the accept replaces the old one.
  assign can_store = !rx_valid || rx_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_dc    <= 1'b0;
    end else if (!live) begin
      rx_valid <= 1'b0;
    end else if (byte_done && can_store) begin
      rx_valid <= 1'b1;
      rx_data  <= byte_nxt;
      rx_dc    <= pin_s[PIN_DC];
    end else if (accept) begin
      rx_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx: SPI mode-0 bytes at 1 MHz SCK, framing errors,
// overrun (holding register or FIFO build), panel reset flush and async system reset.
module tb_oled_spi_rx;
  import oled_pkg::*;

  localparam time CLK_HALF = 10ns;
  localparam time SCK_HALF = 500ns;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        oled_sck = 1'b0;
  logic        oled_mosi = 1'b0;
  logic        oled_cs = 1'b1;
  logic        oled_dc = 1'b0;
  logic        oled_rst = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_dc;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic        rx_overrun;
  logic        rx_frame_err;
  logic [15:0] rx_byte_cnt;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned ovr_cnt = 0;
  int unsigned fe_cnt = 0;
  int unsigned exp_cnt = 0;
  logic [8:0]  got_q [$];

  oled_spi_rx #(.SYNC_STAGES(2), .FIFO_DEPTH(16)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .oled_sck     (oled_sck),
    .oled_mosi    (oled_mosi),
    .oled_cs      (oled_cs),
    .oled_dc      (oled_dc),
    .oled_rst     (oled_rst),
    .rx_data      (rx_data),
    .rx_dc        (rx_dc),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_byte_cnt  (rx_byte_cnt)
  );

  always #(CLK_HALF) sys_clk = ~sys_clk;

  // Stream monitor, sampled mid-cycle ahead of the edge that acts on it.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back({rx_dc, rx_data});
      if (rx_overrun)   ovr_cnt++;
      if (rx_frame_err) fe_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic dc, input logic [7:0] d);
    logic [8:0] e;
    check({tag, "_avail"}, 32'(got_q.size() > 0), 32'd1);
    if (got_q.size() > 0) begin
      e = got_q.pop_front();
      check(tag, 32'(e), 32'({dc, d}));
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge sys_clk);
    #3ns;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      oled_mosi = b[7-i];
      #(SCK_HALF);
      oled_sck = 1'b1;
      #(SCK_HALF);
      oled_sck = 1'b0;
    end
  endtask

  task automatic cs_low(input logic dc);
    oled_dc = dc;
    oled_cs = 1'b0;
    #(SCK_HALF);
  endtask

  task automatic cs_high();
    #(SCK_HALF);
    oled_cs = 1'b1;
    wait_clk(20);
  endtask

  initial begin
    #3ns;
    wait_clk(4);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_cnt", 32'(rx_byte_cnt), 0);
    check("rst_pulses", 32'({rx_overrun, rx_frame_err}), 0);
    sys_rst_n = 1'b1;
    wait_clk(5);

    // 1: single command byte
    cs_low(OLED_DC_CMD);
    send_bits(8'hAE, 8);
    cs_high();
    exp_cnt += 1;
    expect_byte("t1_ae", OLED_DC_CMD, 8'hAE);
    check("t1_extra", 32'(got_q.size()), 0);
    check("t1_cnt", 32'(rx_byte_cnt), exp_cnt);

    // 2: back-to-back data bytes under one cs
    cs_low(OLED_DC_DATA);
    send_bits(8'h01, 8);
    send_bits(8'h80, 8);
    send_bits(8'hFF, 8);
    cs_high();
    exp_cnt += 3;
    expect_byte("t2_01", OLED_DC_DATA, 8'h01);
    expect_byte("t2_80", OLED_DC_DATA, 8'h80);
    expect_byte("t2_ff", OLED_DC_DATA, 8'hFF);
    check("t2_cnt", 32'(rx_byte_cnt), exp_cnt);

    // 3: truncated frame, then a clean byte
    cs_low(OLED_DC_CMD);
    send_bits(8'hA5, 5);
    cs_high();
    check("t3_fe", fe_cnt, 1);
    check("t3_nobyte", 32'(got_q.size()), 0);
    check("t3_cnt", 32'(rx_byte_cnt), exp_cnt);
    cs_low(OLED_DC_CMD);
    send_bits(8'h3C, 8);
    cs_high();
    exp_cnt += 1;
    expect_byte("t3_3c", OLED_DC_CMD, 8'h3C);
    check("t3_fe_after", fe_cnt, 1);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
`ifdef OLED_RX_FIFO_EN
    cs_low(OLED_DC_DATA);
    for (int i = 0; i < 17; i++) send_bits(8'(8'h10 + i), 8);
    cs_high();
    exp_cnt += 17;
    check("t4_ovr", ovr_cnt, 1);
    check("t4_cnt", 32'(rx_byte_cnt), exp_cnt);
    rx_ready = 1'b1;
    wait_clk(30);
    check("t4_n", 32'(got_q.size()), 16);
    for (int i = 0; i < 16; i++) expect_byte("t4_fifo", OLED_DC_DATA, 8'(8'h10 + i));
`else
    cs_low(OLED_DC_DATA);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    cs_high();
    exp_cnt += 2;
    check("t4_ovr", ovr_cnt, 1);
    check("t4_hold", 32'({rx_valid, rx_dc, rx_data}), 32'({1'b1, OLED_DC_DATA, 8'h11}));
    check("t4_cnt", 32'(rx_byte_cnt), exp_cnt);
    rx_ready = 1'b1;
    wait_clk(3);
    check("t4_drained", 32'(rx_valid), 0);
    expect_byte("t4_11", OLED_DC_DATA, 8'h11);
    check("t4_n", 32'(got_q.size()), 0);
`endif

    // 5: panel reset with data pending, then mid-byte
    rx_ready = 1'b0;
    cs_low(OLED_DC_CMD);
    send_bits(8'h77, 8);
    cs_high();
    exp_cnt += 1;
    check("t5_pending", 32'(rx_valid), 1);
    oled_rst = 1'b0;
    wait_clk(6);
    check("t5_flush", 32'(rx_valid), 0);
    oled_rst = 1'b1;
    wait_clk(6);
    rx_ready = 1'b1;
    cs_low(OLED_DC_CMD);
    send_bits(8'h99, 4);
    oled_rst = 1'b0;
    wait_clk(6);
    oled_cs = 1'b1;
    send_bits(8'hFF, 2);
    wait_clk(6);
    oled_rst = 1'b1;
    wait_clk(6);
    check("t5_nofe", fe_cnt, 1);
    check("t5_nobyte", 32'(got_q.size()), 0);
    check("t5_cnt", 32'(rx_byte_cnt), exp_cnt);
    cs_low(OLED_DC_DATA);
    send_bits(8'h55, 8);
    cs_high();
    exp_cnt += 1;
    expect_byte("t5_55", OLED_DC_DATA, 8'h55);
    check("t5_cnt2", 32'(rx_byte_cnt), exp_cnt);

    // 6: asynchronous system reset mid-byte with a byte held
    rx_ready = 1'b0;
    cs_low(OLED_DC_DATA);
    send_bits(8'h5A, 8);
    send_bits(8'hF0, 3);
    #7ns;
    sys_rst_n = 1'b0;
    #1ns;
    check("t6_valid", 32'(rx_valid), 0);
    check("t6_out", 32'({rx_dc, rx_data}), 0);
    check("t6_cnt", 32'(rx_byte_cnt), 0);
    oled_cs = 1'b1;
    oled_sck = 1'b0;
    wait_clk(4);
    sys_rst_n = 1'b1;
    rx_ready = 1'b1;
    wait_clk(4);
    cs_low(OLED_DC_CMD);
    send_bits(8'hC3, 8);
    cs_high();
    expect_byte("t6_c3", OLED_DC_CMD, 8'hC3);
    check("t6_cnt2", 32'(rx_byte_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
